// File: rtl/ldtu_out_fifo.sv
// Output buffer after the TMR control unit: 32-bit word FIFO with idle-word fill, overflow tracking
// and one-slot full reserve. Optional per-slot even parity guarded by LDTU_OUT_FIFO_PARITY_EN.
module ldtu_out_fifo #(
  parameter int                  Nbits_32       = 32,
  parameter int                  FifoDepth_buff = 64,
  parameter int                  bits_ptr       = 6,
  parameter logic [Nbits_32-1:0] IdleWord       = 32'hEAAAAAAA,
  parameter int                  ovfBits        = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                write_signal,
  input  logic [Nbits_32-1:0] DATA_in,
  input  logic                read_signal,
  output logic                full,
  output logic                empty,
  output logic [Nbits_32-1:0] DATA_out,
  output logic                data_valid,
  output logic [bits_ptr:0]   fifo_level,
  output logic                overflow,
  output logic [ovfBits-1:0]  overflow_count
`ifdef LDTU_OUT_FIFO_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam logic [bits_ptr:0]   DepthC = (bits_ptr+1)'(FifoDepth_buff);
  localparam logic [bits_ptr:0]   CntOne = (bits_ptr+1)'(1);
  localparam logic [bits_ptr-1:0] PtrOne = bits_ptr'(1);
  localparam logic [ovfBits-1:0]  OvfOne = ovfBits'(1);

  logic [Nbits_32-1:0] mem_q [FifoDepth_buff];
  logic [bits_ptr-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [bits_ptr:0]   count_q, count_d;
  logic [Nbits_32-1:0] data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                overflow_q, overflow_d;
  logic [ovfBits-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic                rd_ok, wr_ok, wr_drop;

  // A read at full frees a slot on the same edge, so a simultaneous write is still accepted.
  assign rd_ok   = read_signal && (count_q != '0);
  assign wr_ok   = write_signal && ((count_q != DepthC) || rd_ok);
  assign wr_drop = write_signal && !wr_ok;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    ovf_cnt_d    = ovf_cnt_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_ok) begin
      rd_ptr_d     = rd_ptr_q + PtrOne;
      data_out_d   = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end else if (read_signal) begin
      data_out_d = IdleWord;
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntOne;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntOne;
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != '1) begin
        ovf_cnt_d = ovf_cnt_q + OvfOne;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= IdleWord;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= DATA_in;
    end
  end

`ifdef LDTU_OUT_FIFO_PARITY_EN
  logic par_q [FifoDepth_buff];
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q;
    if (rd_ok && ((^mem_q[rd_ptr_q]) != par_q[rd_ptr_q])) begin
      parity_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      par_q[wr_ptr_q] <= ^DATA_in;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign full           = (count_q >= (DepthC - CntOne));
  assign empty          = (count_q == '0);
  assign fifo_level     = count_q;
  assign DATA_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign overflow       = overflow_q;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_ldtu_out_fifo.sv
// Directed bench for ldtu_out_fifo: reset, ordering, full/overflow, streaming wrap, async reset, parity.
module tb_ldtu_out_fifo;

  localparam logic [31:0] IDLE = 32'hEAAAAAAA;

  logic        CLK = 1'b0;
  logic        reset;
  logic        write_signal;
  logic [31:0] DATA_in;
  logic        read_signal;
  logic        full;
  logic        empty;
  logic [31:0] DATA_out;
  logic        data_valid;
  logic [6:0]  fifo_level;
  logic        overflow;
  logic [7:0]  overflow_count;
`ifdef LDTU_OUT_FIFO_PARITY_EN
  logic        parity_err;
`endif

  int errors = 0;
  int checks = 0;

  ldtu_out_fifo dut (
    .CLK           (CLK),
    .reset         (reset),
    .write_signal  (write_signal),
    .DATA_in       (DATA_in),
    .read_signal   (read_signal),
    .full          (full),
    .empty         (empty),
    .DATA_out      (DATA_out),
    .data_valid    (data_valid),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .overflow_count(overflow_count)
`ifdef LDTU_OUT_FIFO_PARITY_EN
    ,
    .parity_err    (parity_err)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    write_signal = 1'b0;
    read_signal  = 1'b0;
    DATA_in      = '0;
    #1;
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", DATA_out, IDLE);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ovfcnt", 32'(overflow_count), 32'd0);
    #11;
    reset = 1'b0;

    // Reads of an empty FIFO return the idle word.
    read_signal = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_dout", DATA_out, IDLE);
      chk("idle_valid", 32'(data_valid), 32'd0);
    end
    read_signal = 1'b0;

    // Three writes, then three ordered reads and one read past empty.
    write_signal = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      DATA_in = 32'h0A000000 + 32'(i);
      tick();
      chk("wr3_level", 32'(fifo_level), 32'(i));
    end
    write_signal = 1'b0;
    chk("wr3_empty", 32'(empty), 32'd0);
    read_signal = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("rd3_dout", DATA_out, 32'h0A000000 + 32'(i));
      chk("rd3_valid", 32'(data_valid), 32'd1);
    end
    tick();
    chk("rd4_dout", DATA_out, IDLE);
    chk("rd4_valid", 32'(data_valid), 32'd0);
    chk("rd4_empty", 32'(empty), 32'd1);
    read_signal = 1'b0;

    // Fill to 63 (full asserts), one in-flight write to 64, then a dropped write.
    write_signal = 1'b1;
    for (int i = 0; i < 63; i++) begin
      DATA_in = 32'h0C000000 + 32'(i);
      tick();
      if (i == 61) chk("fill62_full", 32'(full), 32'd0);
    end
    chk("fill63_full", 32'(full), 32'd1);
    chk("fill63_level", 32'(fifo_level), 32'd63);
    DATA_in = 32'h0C00003F;
    tick();
    chk("fill64_level", 32'(fifo_level), 32'd64);
    chk("fill64_ovf", 32'(overflow), 32'd0);
    DATA_in = 32'h0CDEAD00;
    tick();
    chk("drop_level", 32'(fifo_level), 32'd64);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_ovfcnt", 32'(overflow_count), 32'd1);

    // Read and write together at full: both accepted, no new overflow.
    read_signal = 1'b1;
    DATA_in     = 32'h0C000040;
    tick();
    chk("rwfull_dout", DATA_out, 32'h0C000000);
    chk("rwfull_level", 32'(fifo_level), 32'd64);
    chk("rwfull_ovfcnt", 32'(overflow_count), 32'd1);
    write_signal = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("drain_dout", DATA_out, 32'h0C000000 + 32'(i));
    end
    read_signal = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Fill to 32, then stream 100 cycles of simultaneous read/write across pointer wrap.
    write_signal = 1'b1;
    for (int i = 0; i < 32; i++) begin
      DATA_in = 32'h0D000000 + 32'(i);
      tick();
    end
    chk("fill32_level", 32'(fifo_level), 32'd32);
    read_signal = 1'b1;
    for (int k = 0; k < 100; k++) begin
      DATA_in = 32'h0D000020 + 32'(k);
      tick();
      chk("stream_dout", DATA_out, 32'h0D000000 + 32'(k));
      chk("stream_level", 32'(fifo_level), 32'd32);
    end
    write_signal = 1'b0;

    // Drain down to 10 words, then pulse reset between edges.
    for (int k = 100; k < 122; k++) begin
      tick();
      chk("drain22_dout", DATA_out, 32'h0D000000 + 32'(k));
    end
    read_signal = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd10);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout", DATA_out, IDLE);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_ovfcnt", 32'(overflow_count), 32'd0);
    reset = 1'b0;
    tick();
    write_signal = 1'b1;
    DATA_in      = 32'h0E0000AA;
    tick();
    write_signal = 1'b0;
    read_signal  = 1'b1;
    tick();
    chk("post_rst_dout", DATA_out, 32'h0E0000AA);
    chk("post_rst_valid", 32'(data_valid), 32'd1);
    tick();
    chk("post_rst_idle", DATA_out, IDLE);
    read_signal = 1'b0;

`ifdef LDTU_OUT_FIFO_PARITY_EN
    // Slot 1 after the writes above holds 0F000001, slot 2 holds 0F000002.
    write_signal = 1'b1;
    DATA_in      = 32'h0F000001;
    tick();
    DATA_in      = 32'h0F000002;
    tick();
    write_signal = 1'b0;
    chk("par_clean", 32'(parity_err), 32'd0);
    dut.mem_q[1] = 32'h0F000000;
    read_signal  = 1'b1;
    tick();
    chk("par_dout", DATA_out, 32'h0F000000);
    chk("par_err", 32'(parity_err), 32'd1);
    tick();
    chk("par_dout2", DATA_out, 32'h0F000002);
    chk("par_sticky", 32'(parity_err), 32'd1);
    read_signal = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("par_rst", 32'(parity_err), 32'd0);
    reset = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldtu_out_fifo.md
Name: ldtu_out_fifo

Overview:
- Output buffer directly downstream of the TMR control unit.
- Stores the 32-bit data and trailer words the control unit writes, and tells it when to stop writing via `full`.
- Returns words to the serializer side one at a time on `read_signal`.
- When the buffer has nothing to return, it emits a fixed idle word, so the serializer always gets a defined pattern.

Parameters:
- Nbits_32, 32: word width.
- FifoDepth_buff, 64: number of storage slots; must be a power of 2.
- bits_ptr, 6: pointer width, equal to log2(FifoDepth_buff).
- IdleWord, 32'hEAAAAAAA: word driven when a read finds the FIFO empty. Header nibble 1110 keeps it distinct from the 1111 initial word and the 1101 trailer.
- ovfBits, 8: width of the overflow counter.

Ports:
- CLK  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- write_signal  input  1  write strobe from the control unit (a registered output there).
- DATA_in  input  Nbits_32  word to store; sampled when write_signal=1.
- read_signal  input  1  read request from the handshake logic.
- full  output  1  back-pressure to the control unit.
- empty  output  1  high when the FIFO holds no words.
- DATA_out  output  Nbits_32  registered read data.
- data_valid  output  1  high for one cycle when DATA_out carries a stored word.
- fifo_level  output  bits_ptr+1  current occupancy, 0..FifoDepth_buff.
- overflow  output  1  sticky flag: a write was dropped.
- overflow_count  output  ovfBits  number of dropped writes; saturates at all-ones.

Behaviour:
- Reset: reset=1 clears the following immediately, regardless of clock, and the clear holds while reset=1:
  - write pointer, read pointer and count go to 0;
  - full=0, empty=1;
  - DATA_out=IdleWord, data_valid=0;
  - overflow=0, overflow_count=0.
- Reset mid-operation discards all stored words. Memory contents are not cleared and are don't-care.
- Storage: circular buffer with bits_ptr-bit read and write pointers. Pointers wrap from FifoDepth_buff-1 to 0. The count register is bits_ptr+1 bits wide.
- Write:
  - On a rising CLK edge with write_signal=1 and count<FifoDepth_buff, store DATA_in at the write pointer and increment the write pointer.
  - If count==FifoDepth_buff, drop the word:
    - leave pointers and memory unchanged;
    - set overflow=1;
    - increment overflow_count, saturating at all-ones.
- Full flag:
  - full is combinational from count: full=1 when count>=FifoDepth_buff-1.
  - The one-slot reserve absorbs the write already in flight, because the control unit samples full and asserts write_signal one cycle later.
  - With a correctly behaving control unit, the overflow path is never taken.
- Read:
  - On a rising CLK edge with read_signal=1 and count>0: DATA_out<=mem[read pointer], increment the read pointer, data_valid<=1.
  - With read_signal=1 and count==0: DATA_out<=IdleWord, data_valid<=0.
  - With read_signal=0: DATA_out holds its value and data_valid<=0.
  - Read latency is one cycle from the read_signal edge to DATA_out.
- Simultaneous read and write:
  - Both accepted and count unchanged, provided count>0 and count<FifoDepth_buff.
  - At count==0 only the write takes effect. There is no bypass: the read returns IdleWord.
  - At count==FifoDepth_buff both the read and the write are accepted and count is unchanged. The read frees a slot in the same edge, so no overflow is flagged.
- empty=(count==0), combinational. fifo_level=count.
- Ordering: strict FIFO order. Trailer words receive no special treatment.

Optional Feature:
- Macro: LDTU_OUT_FIFO_PARITY_EN.
- When defined:
  - Each slot stores an extra even-parity bit computed from DATA_in at write time.
  - On every successful read, the stored parity is checked against the read word.
  - A mismatch sets a sticky output parity_err (1 bit). parity_err is cleared only by reset.
  - DATA_out is still delivered unmodified.
- When not defined:
  - No parity storage.
  - parity_err does not exist as a port.

Test Plan:
- Reset then 3 idle cycles, read_signal=1 -> DATA_out=32'hEAAAAAAA, data_valid=0, empty=1, full=0, fifo_level=0.
- Write 0x0A000001, 0x0A000002, 0x0A000003 on consecutive cycles, then read 3 times -> DATA_out=0x0A000001, 0x0A000002, 0x0A000003 in order, each one cycle after its read edge, data_valid=1; a 4th read -> IdleWord, empty=1.
- Write 63 words with no reads -> full=1 after the 63rd write (fifo_level=63). One in-flight write -> fifo_level=64. A further forced write -> dropped, overflow=1, overflow_count=1, stored contents intact.
- Fill to 32, then drive read_signal=1 and write_signal=1 together for 100 cycles with an incrementing pattern -> fifo_level stays 32 and the output sequence matches the input order across pointer wrap-around.
- Fill to 10, assert reset mid-stream for 1 ns between clock edges -> fifo_level=0, empty=1, DATA_out=IdleWord immediately; the next write/read returns the new word only.
- With LDTU_OUT_FIFO_PARITY_EN defined, flip one stored bit via force, then read that word -> parity_err=1, and it stays 1 until reset.
